// File: rtl/ntt_ctrl_if.sv
// -----------------------------------------------------------------------------
// ntt_ctrl_if
// Bus bundle between the NTT sequencer and its environment. The environment
// side holds the coefficient RAM, the twiddle ROM and the butterfly unit.
//
//   start      request a new transform (sampled only when the sequencer idles)
//   op         0 = forward NTT, 1 = inverse NTT (captured with start)
//   stall      issue hold request (only when NTT_CTRL_STALL_EN is defined)
//   busy       run in progress
//   done       one-cycle completion pulse
//   rd_en      coefficient pair read strobe
//   rd_addr_a  index of the a operand
//   rd_addr_b  index of the b operand
//   tw_addr    twiddle ROM index
//   bf_mode    butterfly mode: 00 NTT, 01 INTT, 11 idle
//   wr_en      write-back strobe (c -> wr_addr_a, d -> wr_addr_b)
//   wr_addr_a  write address for c
//   wr_addr_b  write address for d
//
// Modports: master = sequencer side, slave = environment side.
// Optional feature macro: NTT_CTRL_STALL_EN adds the stall signal.
// -----------------------------------------------------------------------------
interface ntt_ctrl_if;
    logic       start;
    logic       op;
`ifdef NTT_CTRL_STALL_EN
    logic       stall;
`endif
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_addr;
    logic [1:0] bf_mode;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

`ifdef NTT_CTRL_STALL_EN
    modport master (
        input  start, op, stall,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_mode, wr_en, wr_addr_a, wr_addr_b
    );
    modport slave (
        output start, op, stall,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_mode, wr_en, wr_addr_a, wr_addr_b
    );
`else
    modport master (
        input  start, op,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_mode, wr_en, wr_addr_a, wr_addr_b
    );
    modport slave (
        output start, op,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               bf_mode, wr_en, wr_addr_a, wr_addr_b
    );
`endif
endinterface

// File: rtl/ntt_ctrl.sv
// -----------------------------------------------------------------------------
// ntt_ctrl
// Sequencer for one butterfly unit running a full 256-point Kyber NTT
// (Cooley-Tukey, forward) or INTT (Gentleman-Sande, inverse): 7 layers of
// 128 butterflies. Each issue cycle reads one coefficient pair and one
// twiddle; write-backs follow D = RD_LAT + BF_LAT cycles later through a
// shift pipeline. After each layer the sequencer waits D cycles so the last
// write of a layer lands before the first read of the next one.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   ntt_ctrl_if.master (start/op in; busy/done, read, twiddle,
//         butterfly mode and write-back signals out; all outputs registered)
//
// Parameters:
//   RD_LAT  read latency of coefficient RAM and twiddle ROM (cycles, >= 1)
//   BF_LAT  butterfly latency from operands to c/d (cycles, >= 1)
//
// Optional feature macro: NTT_CTRL_STALL_EN. When defined, bus.stall held
// high during issue freezes the butterfly index and injects bubbles into the
// write pipeline; operations already in flight still retire on schedule.
// -----------------------------------------------------------------------------
module ntt_ctrl #(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    ntt_ctrl_if.master    bus
);

    localparam int D  = RD_LAT + BF_LAT;
    localparam int CW = $clog2(D + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
    } addr_t;

    // Butterfly operand and twiddle addressing for layer l, butterfly i.
    // len is a power of two, so group/offset come from shift and mask.
    function automatic addr_t addr_gen(input logic inv,
                                       input logic [2:0] l,
                                       input logic [6:0] i);
        logic [2:0] lsh;
        logic [3:0] gsh;
        logic [7:0] len;
        logic [7:0] g;
        logic [7:0] o;
        logic [7:0] a;
        addr_t      r;
        if (inv) begin
            lsh = l + 3'd1;          // len = 2 << l
        end else begin
            lsh = 3'd7 - l;          // len = 128 >> l
        end
        gsh  = {1'b0, lsh} + 4'd1;   // group stride is 2*len
        len  = 8'd1 << lsh;
        g    = {1'b0, i} >> lsh;
        o    = {1'b0, i} & (len - 8'd1);
        a    = (g << gsh) | o;
        r.a  = a;
        r.b  = a + len;
        if (inv) begin
            // (128 >> l) - 1 equals 127 >> l
            r.tw = (7'd127 >> l) - g[6:0];
        end else begin
            r.tw = (7'd1 << l) + g[6:0];
        end
        return r;
    endfunction

    state_t            state_r;
    logic              op_r;
    logic [2:0]        layer_r;
    logic [7:0]        idx_r;          // next butterfly to issue; bit 7 = layer fully issued
    logic [CW-1:0]     drain_r;
    logic              busy_r;
    logic              done_r;
    logic              rd_en_r;
    logic [7:0]        rd_addr_a_r;
    logic [7:0]        rd_addr_b_r;
    logic [6:0]        tw_addr_r;
    logic [1:0]        bf_mode_r;
    logic [RD_LAT-1:0] first_r;        // accepted start delayed toward butterfly arrival

    logic [D-1:0]      wen_pipe_r;
    logic [7:0]        wa_pipe_r [D];
    logic [7:0]        wb_pipe_r [D];

    logic              accept_s;
    logic              stall_s;
    logic              cand_inv_s;
    logic [2:0]        cand_layer_s;
    logic [6:0]        cand_idx_s;
    addr_t             cand_s;

`ifdef NTT_CTRL_STALL_EN
    assign stall_s = bus.stall;
`else
    assign stall_s = 1'b0;
`endif

    assign accept_s = (state_r == ST_IDLE) && bus.start;

    // Address candidate for whichever butterfly the next edge would issue.
    always_comb begin
        cand_inv_s   = op_r;
        cand_layer_s = layer_r;
        cand_idx_s   = idx_r[6:0];
        case (state_r)
            ST_IDLE: begin
                cand_inv_s   = bus.op;
                cand_layer_s = 3'd0;
                cand_idx_s   = 7'd0;
            end
            ST_ISSUE: begin
                cand_idx_s   = idx_r[6:0];
            end
            ST_DRAIN: begin
                cand_layer_s = layer_r + 3'd1;
                cand_idx_s   = 7'd0;
            end
            default: begin
                cand_idx_s   = 7'd0;
            end
        endcase
        cand_s = addr_gen(cand_inv_s, cand_layer_s, cand_idx_s);
    end

    // Main sequencer: run state, counters and all issue-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            op_r        <= 1'b0;
            layer_r     <= 3'd0;
            idx_r       <= 8'd0;
            drain_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_addr_a_r <= 8'd0;
            rd_addr_b_r <= 8'd0;
            tw_addr_r   <= 7'd0;
            bf_mode_r   <= 2'b11;
            first_r     <= '0;
        end else begin
            done_r <= 1'b0;
            for (int k = RD_LAT - 1; k > 0; k--) begin
                first_r[k] <= first_r[k-1];
            end
            first_r[0] <= accept_s;
            // First operands reach the butterfly RD_LAT cycles after the first issue.
            if (first_r[RD_LAT-1]) begin
                bf_mode_r <= {1'b0, op_r};
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r     <= ST_ISSUE;
                        op_r        <= bus.op;
                        layer_r     <= 3'd0;
                        idx_r       <= 8'd1;
                        busy_r      <= 1'b1;
                        rd_en_r     <= 1'b1;
                        rd_addr_a_r <= cand_s.a;
                        rd_addr_b_r <= cand_s.b;
                        tw_addr_r   <= cand_s.tw;
                    end else begin
                        rd_en_r     <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (idx_r[7]) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                        drain_r <= '0;
                    end else if (stall_s) begin
                        rd_en_r <= 1'b0;
                    end else begin
                        rd_en_r     <= 1'b1;
                        rd_addr_a_r <= cand_s.a;
                        rd_addr_b_r <= cand_s.b;
                        tw_addr_r   <= cand_s.tw;
                        idx_r       <= idx_r + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == CW'(D - 1)) begin
                        if (layer_r == 3'd6) begin
                            // Final write retires this cycle: run complete.
                            state_r   <= ST_DONE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            bf_mode_r <= 2'b11;
                        end else begin
                            state_r     <= ST_ISSUE;
                            layer_r     <= layer_r + 3'd1;
                            idx_r       <= 8'd1;
                            rd_en_r     <= 1'b1;
                            rd_addr_a_r <= cand_s.a;
                            rd_addr_b_r <= cand_s.b;
                            tw_addr_r   <= cand_s.tw;
                        end
                    end else begin
                        drain_r <= drain_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Write-back pipeline: issued strobe and addresses delayed by exactly D cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_pipe_r <= '0;
            for (int k = 0; k < D; k++) begin
                wa_pipe_r[k] <= 8'd0;
                wb_pipe_r[k] <= 8'd0;
            end
        end else begin
            wen_pipe_r[0] <= rd_en_r;
            wa_pipe_r[0]  <= rd_addr_a_r;
            wb_pipe_r[0]  <= rd_addr_b_r;
            for (int k = 1; k < D; k++) begin
                wen_pipe_r[k] <= wen_pipe_r[k-1];
                wa_pipe_r[k]  <= wa_pipe_r[k-1];
                wb_pipe_r[k]  <= wb_pipe_r[k-1];
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.rd_addr_a = rd_addr_a_r;
    assign bus.rd_addr_b = rd_addr_b_r;
    assign bus.tw_addr   = tw_addr_r;
    assign bus.bf_mode   = bf_mode_r;
    assign bus.wr_en     = wen_pipe_r[D-1];
    assign bus.wr_addr_a = wa_pipe_r[D-1];
    assign bus.wr_addr_b = wb_pipe_r[D-1];

endmodule
